ap_ctrl_sequencer: RTL and testbench
====================================

AP_CTRL_SEQUENCER -- requirements
Module: ap_ctrl_sequencer

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, setting the width of the transaction count and counters.
REQ-002 The block SHALL have parameter CYC_W, default 32, setting the width of the run-cycle counter.
REQ-003 The block SHALL have port ap_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port ap_rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port cmd_go, input, 1 bit: one-cycle request to start a run.
REQ-006 The block SHALL have port cfg_num_trans, input, CNT_W bits: number of transactions N, sampled only when a run is accepted.
REQ-007 The block SHALL have port dut_ap_start, output, 1 bit: ap_ctrl_hs start driven to the HLS block.
REQ-008 The block SHALL have port dut_ap_ready, input, 1 bit: ap_ctrl_hs ready from the HLS block.
REQ-009 The block SHALL have port dut_ap_done, input, 1 bit: ap_ctrl_hs done from the HLS block.
REQ-010 The block SHALL have port dut_ap_continue, output, 1 bit: constant 1, for ap_ctrl_hs compatibility.
REQ-011 The block SHALL have port busy, output, 1 bit: high in the ISSUE and DRAIN states.
REQ-012 The block SHALL have port finish, output, 1 bit: one-cycle pulse at the end of a run.
REQ-013 The block SHALL have port started_cnt, output, CNT_W bits: accepted starts in the current or last run.
REQ-014 The block SHALL have port done_cnt, output, CNT_W bits: completions in the current or last run.
REQ-015 The block SHALL have port run_cycles, output, CYC_W bits: elapsed cycles of the current or last run.

Function
REQ-016 The block SHALL implement the states IDLE, ISSUE, DRAIN and FIN, with every output registered except dut_ap_continue.
REQ-017 In IDLE, cmd_go with cfg_num_trans != 0 SHALL latch N, clear all three counters, and move to ISSUE on the next edge.
REQ-018 In IDLE, cmd_go with cfg_num_trans == 0 SHALL clear the counters and move to FIN without asserting dut_ap_start.
REQ-019 cmd_go SHALL be ignored in ISSUE, DRAIN and FIN.
REQ-020 In ISSUE, dut_ap_start SHALL be 1 and SHALL NOT drop until a start is accepted (dut_ap_start and dut_ap_ready both 1 at an edge).
REQ-021 Each accepted start SHALL increment started_cnt.
REQ-022 When the accepted start makes started_cnt equal N, dut_ap_start SHALL be 0 from the following cycle.
REQ-023 dut_ap_done sampled high in ISSUE or DRAIN SHALL increment done_cnt, saturating at N.
REQ-024 dut_ap_done in IDLE or FIN SHALL be ignored.
REQ-025 An accepted start and a done in the same cycle SHALL both be counted.
REQ-026 Transitions: ISSUE->DRAIN when the last start is accepted and done_cnt < N afterwards; ISSUE->FIN when the last start and the final done coincide; DRAIN->FIN when done_cnt reaches N.
REQ-027 In FIN, finish SHALL be 1 for exactly one cycle, followed by an unconditional move to IDLE.
REQ-028 run_cycles SHALL increment on every cycle spent in ISSUE or DRAIN and SHALL saturate at all-ones.
REQ-029 The counters SHALL hold their values in IDLE until the next accepted cmd_go.
REQ-030 Overlapped operation (ap_ready preceding ap_done for a pipelined block) SHALL be supported; started_cnt - done_cnt may exceed 1.

Reset
REQ-031 Assertion of ap_rst SHALL immediately force state IDLE and clear dut_ap_start, busy, finish, started_cnt, done_cnt and run_cycles, including mid-run (the run is aborted, no finish pulse).
REQ-032 dut_ap_continue SHALL be 1 during and after reset.

Structure
REQ-033 A package ap_ctrl_seq_pkg SHALL hold the state enum and the default values of CNT_W and CYC_W.
REQ-034 One sub-module, sat_counter (clear, enable, saturate-at-limit, parameterised width), SHALL be instantiated for started_cnt, done_cnt and run_cycles.

Verification
REQ-035 N=3, ready tied 1, done 2 cycles after each start -> dut_ap_start high for 3 cycles, started_cnt=3, done_cnt=3, single finish pulse.
REQ-036 N=2, ready delayed 4 cycles -> dut_ap_start held high continuously for 5 cycles until the first ready.
REQ-037 N=1, ready and done in the same cycle -> ISSUE->FIN directly, finish exactly one cycle later, run_cycles=1.
REQ-038 N=0 -> no dut_ap_start, finish pulse, all counters 0.
REQ-039 N=4 with ap_rst asserted after the second start -> outputs 0 immediately, no finish, and a subsequent go with N=1 completes normally.
REQ-040 cmd_go pulsed while busy, and spurious done in IDLE -> no effect on counters or state.

Source files
------------

// File: rtl/ap_ctrl_seq_pkg.sv
// Shared types and default widths for the ap_ctrl_hs run sequencer.
package ap_ctrl_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_FIN
  } state_e;

  localparam int CNT_W_DEF = 16;
  localparam int CYC_W_DEF = 32;

endpackage

// File: rtl/ap_ctrl_sequencer_sat_counter.sv
// Up-counter with synchronous clear that holds once it reaches lim.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] lim,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != lim)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// Issues N ap_ctrl_hs starts to an HLS block and waits for N dones.
module ap_ctrl_sequencer
  import ap_ctrl_seq_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int CYC_W = CYC_W_DEF
) (
  input  logic             ap_clk,
  input  logic             ap_rst,
  input  logic             cmd_go,
  input  logic [CNT_W-1:0] cfg_num_trans,
  output logic             dut_ap_start,
  input  logic             dut_ap_ready,
  input  logic             dut_ap_done,
  output logic             dut_ap_continue,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] started_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CYC_W-1:0] run_cycles
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             fin_q, fin_d;

  logic             clr;
  logic             in_run;
  logic             acc;
  logic             last;
  logic             dn;
  logic             done_full;
  logic [CNT_W-1:0] n_m1;

  assign n_m1   = n_q - CNT_W'(1);
  assign in_run = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign acc    = (state_q == ST_ISSUE) && start_q && dut_ap_ready;
  assign last   = acc && (started_cnt == n_m1);
  assign dn     = in_run && dut_ap_done && (done_cnt != n_q);

  // True when done_cnt will equal N after this edge.
  assign done_full = (done_cnt == n_q) ||
                     (dn && (done_cnt == n_m1));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    clr     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_go) begin
          clr = 1'b1;
          n_d = cfg_num_trans;
          if (cfg_num_trans == '0) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (last) begin
          state_d = done_full ? ST_FIN : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (done_full) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    start_d = (state_d == ST_ISSUE);
    busy_d  = (state_d == ST_ISSUE) ||
              (state_d == ST_DRAIN);
    fin_d   = (state_d == ST_FIN);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_started (
    .clk (ap_clk),
    .rst (ap_rst),
    .clr (clr),
    .en  (acc),
    .lim (n_q),
    .cnt (started_cnt)
  );

  sat_counter #(.W(CNT_W)) u_done (
    .clk (ap_clk),
    .rst (ap_rst),
    .clr (clr),
    .en  (dn),
    .lim (n_q),
    .cnt (done_cnt)
  );

  sat_counter #(.W(CYC_W)) u_cycles (
    .clk (ap_clk),
    .rst (ap_rst),
    .clr (clr),
    .en  (in_run),
    .lim ({CYC_W{1'b1}}),
    .cnt (run_cycles)
  );

  assign dut_ap_start    = start_q;
  assign dut_ap_continue = 1'b1;
  assign busy            = busy_q;
  assign finish          = fin_q;

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Directed bench for ap_ctrl_sequencer with a small HLS responder.
module tb_ap_ctrl_sequencer;

  localparam int CNT_W = 16;
  localparam int CYC_W = 32;

  logic             clk;
  logic             rst;
  logic             cmd_go;
  logic [CNT_W-1:0] cfg;
  logic             start;
  logic             ready;
  logic             done;
  logic             cont;
  logic             busy;
  logic             finish;
  logic [CNT_W-1:0] started_cnt;
  logic [CNT_W-1:0] done_cnt;
  logic [CYC_W-1:0] run_cycles;

  ap_ctrl_sequencer #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
    .ap_clk          (clk),
    .ap_rst          (rst),
    .cmd_go          (cmd_go),
    .cfg_num_trans   (cfg),
    .dut_ap_start    (start),
    .dut_ap_ready    (ready),
    .dut_ap_done     (done),
    .dut_ap_continue (cont),
    .busy            (busy),
    .finish          (finish),
    .started_cnt     (started_cnt),
    .done_cnt        (done_cnt),
    .run_cycles      (run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  typedef struct {
    int n;
    int rdy;
    int dly;
    bit go_mid;
    int exp_hi;
    int exp_first;
    int exp_run;
    int exp_fin;
    int exp_maxd;
  } vec_t;

  vec_t tbl[5];
  bit   sched[256];

  task automatic run_vec(input vec_t v, input string tag);
    int c, hi, first, fins, fcyc, maxd, d;
    bit acc;
    c = 0; hi = 0; first = 0;
    fins = 0; fcyc = 0; maxd = 0;
    for (int i = 0; i < 256; i++) sched[i] = 1'b0;
    @(negedge clk);
    cmd_go = 1'b1;
    cfg    = CNT_W'(v.n);
    ready  = 1'b0;
    done   = 1'b0;
    while (1) begin
      @(negedge clk);
      c++;
      cmd_go = v.go_mid && (c == 2);
      if (cmd_go) cfg = CNT_W'(7);
      if (start) hi++;
      if (finish) begin
        fins++;
        if (fcyc == 0) fcyc = c;
      end
      d = int'(started_cnt) - int'(done_cnt);
      if (d > maxd) maxd = d;
      if (fcyc != 0 && c >= fcyc + 2) break;
      if (c >= 200) begin
        chk({tag, "_timeout"}, c, 0);
        break;
      end
      ready = (first == 0) ? (c - 1 >= v.rdy) : 1'b1;
      acc = start && ready;
      if (acc && first == 0) first = c;
      if (acc && c + v.dly < 256) sched[c + v.dly] = 1'b1;
      done = sched[c];
    end
    ready  = 1'b0;
    done   = 1'b0;
    cmd_go = 1'b0;
    chk({tag, "_started"}, started_cnt, v.n);
    chk({tag, "_done"}, done_cnt, v.n);
    chk({tag, "_cycles"}, run_cycles, v.exp_run);
    chk({tag, "_start_hi"}, hi, v.exp_hi);
    chk({tag, "_first_acc"}, first, v.exp_first);
    chk({tag, "_fin_pulses"}, fins, 1);
    chk({tag, "_fin_cyc"}, fcyc, v.exp_fin);
    chk({tag, "_maxdiff"}, maxd, v.exp_maxd);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int fins;
    logic [CNT_W-1:0] s0, d0;
    logic [CYC_W-1:0] r0;

    tbl[0] = '{3, 0, 2, 1'b1, 3, 1, 5, 6, 2};
    tbl[1] = '{2, 4, 1, 1'b0, 6, 5, 7, 8, 1};
    tbl[2] = '{4, 0, 3, 1'b0, 4, 1, 7, 8, 3};
    tbl[3] = '{0, 0, 0, 1'b0, 0, 0, 0, 1, 0};
    tbl[4] = '{1, 0, 0, 1'b0, 1, 1, 1, 2, 0};

    rst = 1'b1; cmd_go = 1'b0; cfg = '0;
    ready = 1'b0; done = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_continue", cont, 1);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_cnts", started_cnt | done_cnt, 0);
    chk("rst_cycles", run_cycles, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i], $sformatf("v%0d", i));
    end

    s0 = started_cnt; d0 = done_cnt; r0 = run_cycles;
    done = 1'b1;
    repeat (3) @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    chk("idle_done_started", started_cnt, s0);
    chk("idle_done_done", done_cnt, d0);
    chk("idle_done_cycles", run_cycles, r0);
    chk("idle_done_busy", busy, 0);
    chk("idle_done_start", start, 0);

    cmd_go = 1'b1; cfg = CNT_W'(4); ready = 1'b1;
    @(negedge clk);
    cmd_go = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_pre_started", started_cnt, 2);
    chk("abort_pre_busy", busy, 1);
    ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_start", start, 0);
    chk("abort_busy", busy, 0);
    chk("abort_finish", finish, 0);
    chk("abort_started", started_cnt, 0);
    chk("abort_done", done_cnt, 0);
    chk("abort_cycles", run_cycles, 0);
    chk("abort_continue", cont, 1);
    @(negedge clk);
    rst = 1'b0;
    fins = 0;
    repeat (5) begin
      @(negedge clk);
      if (finish) fins++;
    end
    chk("abort_no_finish", fins, 0);
    chk("abort_idle_busy", busy, 0);
    run_vec(tbl[4], "post_abort");

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
